array_1_ctrl: RTL and testbench
===============================

# array_1_ctrl

Request front end for the single-port 128x128 masked array macro (`array_1_ext`). It accepts independent write and read request streams over valid/ready and arbitrates them onto the array's single RW port, one access per cycle. It captures read data exactly one cycle after issue into a small response buffer, which gives downstream consumers full backpressure. All traffic to `array_1_ext` passes through this block; the macro's clock is tied to `clock` at the parent.

## Interface
Parameters:
- ADDR_W, 7, array address width
- DATA_W, 128, data width
- MASK_W, 4, write-mask bits, each covering DATA_W/MASK_W bits
- RSP_DEPTH, 2, response buffer entries (minimum 2)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- wr_valid / wr_ready  in / out  1 / 1  write request handshake
- wr_addr / wr_mask / wr_data  in  ADDR_W / MASK_W / DATA_W  write request payload
- rd_valid / rd_ready  in / out  1 / 1  read request handshake
- rd_addr  in  ADDR_W  read address
- rsp_valid / rsp_ready  out / in  1 / 1  read response handshake
- rsp_data  out  DATA_W  read response data
- RW0_en, RW0_wmode  out  1, 1  array enable and write mode
- RW0_addr, RW0_wmask, RW0_wdata  out  ADDR_W, MASK_W, DATA_W  array request
- RW0_rdata  in  DATA_W  array read data, valid the cycle after a read

## Operation
- Array request signals are driven combinationally from the granted request, so the array access happens in the handshake cycle.
- `outstanding` = in-flight read (0/1) + buffer occupancy. A read is eligible when `outstanding < RSP_DEPTH`, or when `outstanding == RSP_DEPTH` and `rsp_valid && rsp_ready` hold this cycle.
- Arbitration without the macro: fixed write priority. An eligible read is granted only when `wr_valid` is low.
- Write with `wr_mask == 0`: accepted (`wr_ready` high), `RW0_en` stays low, no array access.
- Read capture: the in-flight flag is set at issue. On the next cycle `RW0_rdata` is pushed unconditionally into the buffer tail. Capture is never deferred, because the array output is not stable across later writes. Credit accounting guarantees a free slot.
- Response buffer: FIFO; responses are returned in issue order.
- Simultaneous push and pop: both occur; occupancy is unchanged.
- `rd_ready` combinationally depends on `rsp_ready`. `wr_ready` depends on nothing but reset.
- During reset both ready outputs are low and `RW0_en` is low.
- Reset asserted mid-operation clears the in-flight flag, buffer occupancy and the arbiter pointer. A pending response is discarded and never presented.

## Timing
- Reset values: `rsp_valid` = 0, `rsp_data` = 0, `RW0_en` = 0, `RW0_wmode` = 0, `wr_ready` = 0, `rd_ready` = 0.
- Read latency: read handshake in cycle N, `RW0_rdata` valid in N+1, `rsp_valid` high from N+2.
- Throughput: one read per cycle when `rsp_ready` is held high; one access of either kind per cycle.
- Write visibility: a write in cycle N is visible to a read issued in N+1 or later.

## Configuration
- `ARRAY_1_CTRL_RR_ARB_EN` defined: round-robin arbitration.
  - When both requests are eligible, grant the type not granted last.
  - The pointer resets to "write granted last", so a read wins the first conflict.
  - The pointer updates only on a grant.
- Undefined: fixed write priority, no pointer register.

## Structure
- Shared package `array_1_pkg`: `ADDR_W`, `DATA_W`, `MASK_W`, `MASK_GRAN` (=32), `RSP_DEPTH`, and a `req_kind_e` enum (IDLE, WRITE, READ).
- One sub-module, `array_1_rsp_buf`: RSP_DEPTH-entry FIFO with push, pop and occupancy outputs. Its output register drives `rsp_data`.

## Test plan
- Full write, then read: write addr 0x05, mask 0xF, data 0x0123…CDEF. Read 0x05 in the next cycle -> `rsp_data` = 0x0123…CDEF with `rsp_valid` at issue+2.
- Partial write: initialise addr 0x10 to all-ones, write mask 0x2, data 0 -> read returns 0xFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF.
- Conflict, macro off: `wr_valid` and `rd_valid` both high to addr 0x20. Write is granted in cycle N, read in N+1 -> read returns the newly written data.
- Backpressure: `rsp_ready` = 0, three back-to-back reads to 1, 2, 3.
  - Two are accepted; `rd_ready` = 0 for the third.
  - After `rsp_ready` rises, responses arrive in order 1, 2, 3; no loss or duplication.
- Reset mid-flight: read accepted in cycle N, reset pulsed in N+1 -> `rsp_valid` stays 0 after release and `outstanding` = 0.
- Macro on, both streams always valid: grants alternate R, W, R, W starting with R. Mask-0 write -> `RW0_en` low that cycle and `wr_ready` high.

Source files
------------

// File: rtl/array_1_pkg.sv
// array_1_pkg: shared widths, depths and request-kind encoding for the array_1 front end.
package array_1_pkg;
   localparam int ADDR_W    = 7;
   localparam int DATA_W    = 128;
   localparam int MASK_W    = 4;
   localparam int MASK_GRAN = DATA_W / MASK_W;
   localparam int RSP_DEPTH = 2;
   typedef enum logic [1:0] {IDLE, WRITE, READ} req_kind_e;
endpackage

// File: rtl/array_1_rsp_buf.sv
// array_1_rsp_buf: DEPTH-entry in-order response FIFO; entry 0 is the output register.
//   clock, reset           clock and async active-high reset
//   push, push_data        unconditional capture of array read data
//   rsp_ready              downstream ready
//   rsp_valid, rsp_data    head of FIFO
//   pop, occ               pop this cycle and current occupancy
module array_1_rsp_buf #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         rsp_ready,
   output logic                         rsp_valid,
   output logic [DATA_W-1:0]            rsp_data,
   output logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   occ
);
   localparam int CW = $clog2(DEPTH + 1);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [CW-1:0]     occ_q, occ_d, widx;
   // Shift-down FIFO: the head always sits in mem_q[0], so rsp_data is a flop output.
   always_comb begin
      pop   = (occ_q != '0) && rsp_ready;
      widx  = pop ? occ_q - CW'(1) : occ_q;
      occ_d = occ_q + CW'(push) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = (pop && i < DEPTH - 1) ? mem_q[(i + 1) % DEPTH] : mem_q[i];
         if (push && widx == CW'(i)) mem_d[i] = push_data;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         occ_q <= occ_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end
   assign rsp_valid = occ_q != '0;
   assign rsp_data  = mem_q[0];
   assign occ       = occ_q;
endmodule

// File: rtl/array_1_ctrl.sv
// array_1_ctrl: arbitrates write/read request streams onto the single RW port of array_1_ext.
//   clock, reset                          clock and async active-high reset
//   wr_valid/wr_ready, wr_addr/mask/data  write request stream
//   rd_valid/rd_ready, rd_addr            read request stream
//   rsp_valid/rsp_ready, rsp_data         read response stream (in issue order)
//   RW0_en/wmode/addr/wmask/wdata/rdata   array port, rdata valid the cycle after a read
//   ARRAY_1_CTRL_RR_ARB_EN                defined: round-robin arbitration, else fixed write priority
module array_1_ctrl #(
   parameter int ADDR_W    = array_1_pkg::ADDR_W,
   parameter int DATA_W    = array_1_pkg::DATA_W,
   parameter int MASK_W    = array_1_pkg::MASK_W,
   parameter int RSP_DEPTH = array_1_pkg::RSP_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [MASK_W-1:0] wr_mask,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic [MASK_W-1:0] RW0_wmask,
   output logic [DATA_W-1:0] RW0_wdata,
   input  logic [DATA_W-1:0] RW0_rdata
);
   import array_1_pkg::*;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int OW = $clog2(RSP_DEPTH + 2);
   logic          infl_q, infl_d;
   logic [CW-1:0] occ;
   logic [OW-1:0] outstanding;
   logic          pop, rd_elig;
   req_kind_e     gnt;
   // A read may issue into a full credit pool only if a slot frees this same cycle.
   assign outstanding = OW'(occ) + OW'(infl_q);
   assign rd_elig     = (outstanding < OW'(RSP_DEPTH)) || (outstanding == OW'(RSP_DEPTH) && pop);
`ifdef ARRAY_1_CTRL_RR_ARB_EN
   req_kind_e last_q, last_d;
   logic      rd_turn;
   always_comb begin
      rd_turn  = last_q == WRITE;
      wr_ready = !reset && !(rd_valid && rd_elig && rd_turn);
      rd_ready = !reset && rd_elig && !(wr_valid && !rd_turn);
      last_d   = (gnt == IDLE) ? last_q : gnt;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) last_q <= WRITE;
      else last_q <= last_d;
   end
`else
   assign wr_ready = !reset;
   assign rd_ready = !reset && rd_elig && !wr_valid;
`endif
   always_comb begin
      gnt       = (wr_valid && wr_ready) ? WRITE : (rd_valid && rd_ready) ? READ : IDLE;
      RW0_en    = (gnt == WRITE && wr_mask != '0) || gnt == READ;
      RW0_wmode = gnt == WRITE;
      RW0_addr  = (gnt == WRITE) ? wr_addr : rd_addr;
      RW0_wmask = (gnt == WRITE) ? wr_mask : '0;
      RW0_wdata = wr_data;
      infl_d    = gnt == READ;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) infl_q <= 1'b0;
      else infl_q <= infl_d;
   end
   array_1_rsp_buf #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (infl_q),
      .push_data (RW0_rdata),
      .rsp_ready (rsp_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .pop       (pop),
      .occ       (occ)
   );
endmodule

// File: tb/tb_array_1_ctrl.sv
// tb_array_1_ctrl: directed self-checking bench for array_1_ctrl with a behavioural array model.
module tb_array_1_ctrl;
   import array_1_pkg::*;
   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              wr_valid = 1'b0, rd_valid = 1'b0, rsp_ready = 1'b1;
   logic              wr_ready, rd_ready, rsp_valid;
   logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
   logic [MASK_W-1:0] wr_mask = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [DATA_W-1:0] rsp_data;
   logic              RW0_en, RW0_wmode;
   logic [ADDR_W-1:0] RW0_addr;
   logic [MASK_W-1:0] RW0_wmask;
   logic [DATA_W-1:0] RW0_wdata;
   logic [DATA_W-1:0] RW0_rdata = '0;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   int total = 0;
   int bad = 0;
   localparam logic [127:0] D1 = 128'h0123456789abcdef0123456789abcdef;
   localparam logic [127:0] D3 = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
   localparam logic [127:0] V1 = 128'h11111111_11111111_11111111_11111111;
   localparam logic [127:0] V2 = 128'h22222222_22222222_22222222_22222222;
   localparam logic [127:0] V3 = 128'h33333333_33333333_33333333_33333333;
   localparam logic [127:0] PART = 128'hffffffff_ffffffff_00000000_ffffffff;

   array_1_ctrl dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr), .RW0_wmask(RW0_wmask),
      .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (RW0_en) begin
         if (RW0_wmode) begin
            for (int m = 0; m < MASK_W; m++)
               if (RW0_wmask[m]) mem[RW0_addr][m*MASK_GRAN +: MASK_GRAN] = RW0_wdata[m*MASK_GRAN +: MASK_GRAN];
         end else RW0_rdata <= mem[RW0_addr];
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a);
      rd_valid = 1'b1; rd_addr = a;
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input logic [127:0] exp);
      int n = 0;
      while (!rsp_valid && n < 8) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, rsp_valid, 1);
      chk(tag, rsp_data, exp);
      tick();
   endtask

   initial begin
      wr_valid = 1'b1; rd_valid = 1'b1; wr_mask = '1;
      #12;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_en", RW0_en, 0);
      chk("rst_wmode", RW0_wmode, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      wr_valid = 1'b0; rd_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      // full write then read next cycle, exact latency
      wr_valid = 1'b1; wr_addr = 7'h05; wr_mask = 4'hf; wr_data = D1;
      #1;
      chk("w1_ready", wr_ready, 1);
      chk("w1_en", RW0_en, 1);
      chk("w1_wmode", RW0_wmode, 1);
      chk("w1_addr", RW0_addr, 7'h05);
      tick();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 7'h05;
      #1;
      chk("r1_ready", rd_ready, 1);
      chk("r1_wmode", RW0_wmode, 0);
      tick();
      rd_valid = 1'b0;
      chk("r1_n1_valid", rsp_valid, 0);
      tick();
      chk("r1_n2_valid", rsp_valid, 1);
      chk("r1_data", rsp_data, D1);
      tick();
      chk("r1_popped", rsp_valid, 0);
      // partial write
      wr(7'h10, 4'hf, '1);
      wr(7'h10, 4'h2, '0);
      rd(7'h10);
      wait_rsp("partial", PART);
`ifndef ARRAY_1_CTRL_RR_ARB_EN
      // conflict with fixed write priority
      wr_valid = 1'b1; wr_addr = 7'h20; wr_mask = 4'hf; wr_data = D3;
      rd_valid = 1'b1; rd_addr = 7'h20;
      #1;
      chk("cf_wr_ready", wr_ready, 1);
      chk("cf_rd_ready", rd_ready, 0);
      chk("cf_wmode", RW0_wmode, 1);
      tick();
      wr_valid = 1'b0;
      #1;
      chk("cf_rd_ready2", rd_ready, 1);
      chk("cf_rd_wmode", RW0_wmode, 0);
      tick();
      rd_valid = 1'b0;
      wait_rsp("cf_data", D3);
`endif
      // backpressure
      wr(7'h01, 4'hf, V1);
      wr(7'h02, 4'hf, V2);
      wr(7'h03, 4'hf, V3);
      rsp_ready = 1'b0;
      rd_valid = 1'b1; rd_addr = 7'h01;
      #1;
      chk("bp_rd1_ready", rd_ready, 1);
      tick();
      rd_addr = 7'h02;
      #1;
      chk("bp_rd2_ready", rd_ready, 1);
      tick();
      rd_addr = 7'h03;
      #1;
      chk("bp_rd3_blocked", rd_ready, 0);
      tick();
      chk("bp_rd3_blocked2", rd_ready, 0);
      chk("bp_head_valid", rsp_valid, 1);
      chk("bp_head1", rsp_data, V1);
      rsp_ready = 1'b1;
      #1;
      chk("bp_rd3_ready", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      chk("bp_head2", rsp_data, V2);
      chk("bp_head2_valid", rsp_valid, 1);
      tick();
      chk("bp_head3", rsp_data, V3);
      chk("bp_head3_valid", rsp_valid, 1);
      tick();
      chk("bp_drained", rsp_valid, 0);
      // reset mid-flight
      rd_valid = 1'b1; rd_addr = 7'h05;
      #1;
      chk("mr_rd_ready", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mr_wr_ready", wr_ready, 0);
      chk("mr_rd_ready0", rd_ready, 0);
      chk("mr_en", RW0_en, 0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("mr_rsp_valid", rsp_valid, 0);
         chk("mr_outstanding", dut.outstanding, 0);
         tick();
      end
      // mask-0 write: accepted, no access, contents unchanged
      wr_valid = 1'b1; wr_addr = 7'h05; wr_mask = 4'h0; wr_data = '0;
      #1;
      chk("m0_ready", wr_ready, 1);
      chk("m0_en", RW0_en, 0);
      tick();
      wr_valid = 1'b0;
      rd(7'h05);
      wait_rsp("m0_keep", D1);
`ifdef ARRAY_1_CTRL_RR_ARB_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wr_valid = 1'b1; wr_addr = 7'h30; wr_mask = 4'hf; wr_data = D3;
      rd_valid = 1'b1; rd_addr = 7'h30;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_wmode", RW0_wmode, k % 2);
         chk("rr_en", RW0_en, 1);
         tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("rr_drained", rsp_valid, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
